alu_uart_sequencer: RTL and testbench

//  Sequences the UART<->ALU loop: gathers operand A, operand B and opcode from RX bytes,

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_timer.sv | 31 +++
 rtl/alu_uart_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_uart_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the UART<->ALU sequencer.
// One-hot state encoding plus default widths and timeout.
package alu_seq_pkg;

  localparam int SIZEDATA_DEF = 8;
  localparam int SIZEOP_DEF   = 6;
  localparam int TIMEOUT_DEF  = 50000;

  localparam int ST_W   = 6;
  localparam int S_OPA  = 0;
  localparam int S_OPB  = 1;
  localparam int S_OPC  = 2;
  localparam int S_EXEC = 3;
  localparam int S_SEND = 4;
  localparam int S_WAIT = 5;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_OPA  = 6'b000001;
  localparam state_t ST_OPB  = 6'b000010;
  localparam state_t ST_OPC  = 6'b000100;
  localparam state_t ST_EXEC = 6'b001000;
  localparam state_t ST_SEND = 6'b010000;
  localparam state_t ST_WAIT = 6'b100000;

endpackage

// File: rtl/alu_seq_timer.sv
// Inter-byte timeout counter: clears on i_clear, counts while i_enable,
// o_expire is high on the cycle the count sits at TIMEOUT-1.
// Ports: i_clock, i_reset (sync, active-high), i_clear, i_enable, o_expire.
module alu_seq_timer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      cnt <= '0;
    end else if (i_enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expire = i_enable && (cnt == LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// UART<->ALU frame sequencer: gathers A, B, opcode from RX bytes, waits
// ALU_LAT cycles, then hands the result byte to TX with a start/done pulse.
// Ports: i_clock, i_reset (sync, active-high), i_rx_done/i_rx_data,
//  i_alu_result, i_tx_done; o_alu_datoa/datob/opcode, o_tx_start,
//  o_tx_data, o_busy, o_overrun, o_frame_err.
// Optional inter-byte timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SIZEDATA = SIZEDATA_DEF,
  parameter int SIZEOP   = SIZEOP_DEF,
  parameter int ALU_LAT  = 1,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_rx_data,
  input  logic [SIZEDATA-1:0] i_alu_result,
  input  logic                i_tx_done,
  output logic [SIZEDATA-1:0] o_alu_datoa,
  output logic [SIZEDATA-1:0] o_alu_datob,
  output logic [SIZEOP-1:0]   o_alu_opcode,
  output logic                o_tx_start,
  output logic [SIZEDATA-1:0] o_tx_data,
  output logic                o_busy,
  output logic                o_overrun,
  output logic                o_frame_err
);

  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);

  state_t        state;
  state_t        nxt;
  logic [LW-1:0] lat_cnt;
  logic          lat_last;
  logic          accept;
  logic          busy_st;
  logic          tmo;
  logic          overrun_q;
  logic          frame_err_q;

  assign busy_st = state[S_EXEC] | state[S_SEND] | state[S_WAIT];
  assign accept  = i_rx_done & ~busy_st;
  assign lat_last = state[S_EXEC] && (lat_cnt == LAT_LAST);

`ifdef ALU_SEQ_TIMEOUT_EN
  logic expire;

  alu_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (accept),
    .i_enable (state[S_OPB] | state[S_OPC]),
    .o_expire (expire)
  );

  // A byte landing on the expiry cycle wins over the timeout.
  assign tmo = expire & ~i_rx_done;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign tmo = 1'b0;
`endif

  // Opcode takes only the low SIZEOP bits of its byte.
  logic unused_rx_hi;
  assign unused_rx_hi = ^i_rx_data[SIZEDATA-1:SIZEOP];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_OPA;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      state[S_OPA]: begin
        if (i_rx_done) nxt = ST_OPB;
      end
      state[S_OPB]: begin
        if (i_rx_done) nxt = ST_OPC;
        else if (tmo) nxt = ST_OPA;
      end
      state[S_OPC]: begin
        if (i_rx_done) nxt = ST_EXEC;
        else if (tmo) nxt = ST_OPA;
      end
      state[S_EXEC]: begin
        if (lat_last) nxt = ST_SEND;
      end
      state[S_SEND]: begin
        nxt = ST_WAIT;
      end
      state[S_WAIT]: begin
        if (i_tx_done) nxt = ST_OPA;
      end
      default: nxt = ST_OPA;
    endcase
  end

  always_comb begin
    o_tx_start  = state[S_SEND];
    o_busy      = busy_st;
    o_overrun   = overrun_q;
    o_frame_err = frame_err_q;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_alu_datoa  <= '0;
      o_alu_datob  <= '0;
      o_alu_opcode <= '0;
      o_tx_data    <= '0;
      lat_cnt      <= '0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (accept && state[S_OPA]) o_alu_datoa <= i_rx_data;
      if (accept && state[S_OPB]) o_alu_datob <= i_rx_data;
      if (accept && state[S_OPC]) o_alu_opcode <= i_rx_data[SIZEOP-1:0];
      if (lat_last) o_tx_data <= i_alu_result;
      lat_cnt     <= state[S_EXEC] ? lat_cnt + 1'b1 : '0;
      overrun_q   <= i_rx_done & busy_st;
      frame_err_q <= tmo;
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer: ALU_LAT=1 and ALU_LAT=3 instances.
// Build with ALU_SEQ_TIMEOUT_EN to exercise the inter-byte timeout.
module tb_alu_uart_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rxd1, txd1, rxd3, txd3;
  logic [7:0] rxb1, rxb3;
  logic [7:0] a1, b1, txb1, alu1, a3, b3, txb3, alu3;
  logic [5:0] op1, op3;
  logic       txs1, busy1, ovr1, ferr1;
  logic       txs3, busy3, ovr3, ferr3;

  int total = 0;
  int bad = 0;

  assign alu1 = (op1 == 6'h20) ? a1 + b1 : a1 - b1;
  assign alu3 = (op3 == 6'h20) ? a3 + b3 : a3 - b3;

  alu_uart_sequencer u_dut1 (
    .i_clock(clk), .i_reset(rst),
    .i_rx_done(rxd1), .i_rx_data(rxb1),
    .i_alu_result(alu1), .i_tx_done(txd1),
    .o_alu_datoa(a1), .o_alu_datob(b1), .o_alu_opcode(op1),
    .o_tx_start(txs1), .o_tx_data(txb1), .o_busy(busy1),
    .o_overrun(ovr1), .o_frame_err(ferr1)
  );

  alu_uart_sequencer #(.ALU_LAT(3), .TIMEOUT(16)) u_dut3 (
    .i_clock(clk), .i_reset(rst),
    .i_rx_done(rxd3), .i_rx_data(rxb3),
    .i_alu_result(alu3), .i_tx_done(txd3),
    .o_alu_datoa(a3), .o_alu_datob(b3), .o_alu_opcode(op3),
    .o_tx_start(txs3), .o_tx_data(txb3), .o_busy(busy3),
    .o_overrun(ovr3), .o_frame_err(ferr3)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input bit u, input logic [7:0] b);
    if (u) begin rxb3 = b; rxd3 = 1'b1; end
    else begin rxb1 = b; rxd1 = 1'b1; end
    tick();
    rxd1 = 1'b0;
    rxd3 = 1'b0;
  endtask

  task automatic txdone(input bit u);
    if (u) txd3 = 1'b1;
    else txd1 = 1'b1;
    tick();
    txd1 = 1'b0;
    txd3 = 1'b0;
  endtask

  // Sends a frame to the ALU_LAT=1 unit and checks the SEND cycle.
  task automatic frame1(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] exp);
    rx(1'b0, a);
    rx(1'b0, b);
    rx(1'b0, op);
    tick();
    check({tag, "_start"}, 32'(txs1), 1);
    check({tag, "_data"}, 32'(txb1), 32'(exp));
  endtask

  initial begin
    bit seen;
    int n;
    rst = 1'b1;
    rxd1 = 1'b0; txd1 = 1'b0; rxb1 = '0;
    rxd3 = 1'b0; txd3 = 1'b0; rxb3 = '0;
    tick();
    tick();
    check("rst_start", 32'(txs1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_a", 32'(a1), 0);
    check("rst_txd", 32'(txb1), 0);
    check("rst_ovr", 32'(ovr1), 0);
    check("rst_ferr", 32'(ferr1), 0);
    rst = 1'b0;
    tick();

    // 1: basic ADD frame, start two cycles after the opcode pulse
    rx(1'b0, 8'h05);
    rx(1'b0, 8'h03);
    rx(1'b0, 8'h20);
    check("t1_a", 32'(a1), 32'h05);
    check("t1_b", 32'(b1), 32'h03);
    check("t1_op", 32'(op1), 32'h20);
    check("t1_early", 32'(txs1), 0);
    check("t1_busy", 32'(busy1), 1);
    tick();
    check("t1_start", 32'(txs1), 1);
    check("t1_data", 32'(txb1), 32'h08);
    tick();
    check("t1_pulse", 32'(txs1), 0);
    check("t1_hold", 32'(txb1), 32'h08);
    txdone(1'b0);
    check("t1_idle", 32'(busy1), 0);

    // 2: byte dropped in WAIT_TX
    frame1("t2f", 8'h10, 8'h22, 8'h20, 8'h32);
    tick();
    rx(1'b0, 8'h11);
    check("t2_ovr", 32'(ovr1), 1);
    check("t2_txd", 32'(txb1), 32'h32);
    check("t2_busy", 32'(busy1), 1);
    tick();
    check("t2_ovr_end", 32'(ovr1), 0);
    txdone(1'b0);
    frame1("t2g", 8'h01, 8'h02, 8'h20, 8'h03);
    check("t2_a", 32'(a1), 32'h01);
    tick();
    txdone(1'b0);

    // 3: ALU_LAT=3, upper opcode bits dropped, start four cycles later
    rx(1'b1, 8'h07);
    rx(1'b1, 8'h02);
    rx(1'b1, 8'hE2);
    check("t3_op", 32'(op3), 32'h22);
    check("t3_c1", 32'(txs3), 0);
    tick();
    check("t3_c2", 32'(txs3), 0);
    tick();
    check("t3_c3", 32'(txs3), 0);
    tick();
    check("t3_c4", 32'(txs3), 1);
    check("t3_data", 32'(txb3), 32'h05);
    tick();
    txdone(1'b1);
    check("t3_idle", 32'(busy3), 0);

    // 4: reset while in EXEC aborts the frame
    rx(1'b0, 8'h40);
    rx(1'b0, 8'h04);
    rx(1'b0, 8'h20);
    check("t4_exec", 32'(busy1), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_start", 32'(txs1), 0);
    check("t4_busy", 32'(busy1), 0);
    check("t4_a", 32'(a1), 0);
    check("t4_op", 32'(op1), 0);
    check("t4_txd", 32'(txb1), 0);
    tick();
    check("t4_nostart", 32'(txs1), 0);
    frame1("t4f", 8'h0A, 8'h03, 8'h21, 8'h07);
    tick();
    txdone(1'b0);

    // 5: idle gap after operand A
`ifdef ALU_SEQ_TIMEOUT_EN
    rx(1'b1, 8'h09);
    n = 0;
    while (!ferr3 && n < 40) begin
      tick();
      n++;
    end
    check("t5_tmo_cyc", 32'(n), 16);
    check("t5_busy", 32'(busy3), 0);
    check("t5_keep_a", 32'(a3), 32'h09);
    tick();
    check("t5_ferr_end", 32'(ferr3), 0);
    rx(1'b1, 8'h01);
    rx(1'b1, 8'h02);
    rx(1'b1, 8'h20);
    tick();
    tick();
    tick();
    check("t5_start", 32'(txs3), 1);
    check("t5_data", 32'(txb3), 32'h03);
`else
    rx(1'b1, 8'h09);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= ferr3;
    end
    check("t5_no_ferr", 32'(seen), 0);
    rx(1'b1, 8'h04);
    rx(1'b1, 8'h20);
    tick();
    tick();
    tick();
    check("t5_start", 32'(txs3), 1);
    check("t5_data", 32'(txb3), 32'h0D);
`endif
    tick();
    txdone(1'b1);

    // 6: rx and tx done together in WAIT_TX
    frame1("t6f", 8'h20, 8'h05, 8'h20, 8'h25);
    tick();
    rxb1 = 8'h77;
    rxd1 = 1'b1;
    txd1 = 1'b1;
    tick();
    rxd1 = 1'b0;
    txd1 = 1'b0;
    check("t6_busy", 32'(busy1), 0);
    check("t6_ovr", 32'(ovr1), 1);
    check("t6_a_kept", 32'(a1), 32'h20);
    tick();
    check("t6_ovr_end", 32'(ovr1), 0);
    frame1("t6g", 8'h30, 8'h01, 8'h20, 8'h31);
    check("t6_a_new", 32'(a1), 32'h30);
    tick();
    txdone(1'b0);
    check("t6_idle", 32'(busy1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
